// File: rtl/count_unwinder_if.sv
// Load handshake and unwind status bundle for count_unwinder.
// The master drives load/step controls; the slave (the unwinder) returns the count pair and status.
interface count_unwinder_if #(
  parameter int WIDTH = 10
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_sn;
  logic [WIDTH-1:0] load_i;
  logic             selector;
  logic             abort;
  logic [WIDTH-1:0] sn;
  logic [WIDTH-1:0] i;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output load_valid, load_sn, load_i, selector, abort,
    input  load_ready, sn, i, busy, done, err
  );

  modport slave (
    input  load_valid, load_sn, load_i, selector, abort,
    output load_ready, sn, i, busy, done, err
  );
endinterface

// File: rtl/count_unwinder.sv
// Rewinds a forward {sn, i} count snapshot back to {0, 1}, one step per selector cycle.
// Optional load validation is compiled in with `define UNWIND_CHECK_EN.
module count_unwinder #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 300
) (
  input  logic             clk,
  input  logic             rst,
  count_unwinder_if.slave  u
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  // The largest legal forward i must be representable, or the bound check is meaningless.
  if (LIMIT + 1 >= (1 << WIDTH)) begin : g_limit_check
    $error("count_unwinder: LIMIT+1 does not fit in WIDTH bits");
  end

  state_e           state_q;
  logic [WIDTH-1:0] sn_q;
  logic [WIDTH-1:0] i_q;
  logic             done_q;
  logic             err_q;

  logic             load_fire;
  logic             load_bad;

`ifdef UNWIND_CHECK_EN
  localparam logic [WIDTH-1:0] MAX_I = WIDTH'(LIMIT + 1);
  logic [WIDTH-1:0] load_pred;

  always_comb begin
    load_pred = u.load_i - ONE;
    load_bad  = (u.load_i == '0) || (u.load_i > MAX_I) || (u.load_sn != load_pred);
  end
`else
  assign load_bad = 1'b0;
`endif

  assign load_fire = u.load_valid && (state_q == ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sn_q    <= '0;
      i_q     <= ONE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; only the branch that fires raises them.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (load_fire) begin
            if (load_bad) begin
              err_q <= 1'b1;
            end else begin
              sn_q <= u.load_sn;
              i_q  <= u.load_i;
              if (u.load_i > ONE) begin
                state_q <= ST_DRAIN;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          // Abort wins over a coincident step and leaves the pair where it stands.
          if (u.abort) begin
            state_q <= ST_IDLE;
          end else if (u.selector && (i_q > ONE)) begin
            i_q  <= i_q - ONE;
            sn_q <= sn_q - ONE;
            if (i_q == TWO) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign u.load_ready = (state_q == ST_IDLE);
  assign u.busy       = (state_q != ST_IDLE);
  assign u.sn         = sn_q;
  assign u.i          = i_q;
  assign u.done       = done_q;
  assign u.err        = err_q;

  a_done_single : assert property (@(posedge clk) disable iff (rst) done_q |=> !done_q);
  a_err_idle    : assert property (@(posedge clk) disable iff (rst) err_q |-> (state_q == ST_IDLE));
  a_drain_i     : assert property (@(posedge clk) disable iff (rst) (state_q == ST_DRAIN) |-> (i_q > ONE));

endmodule

// File: tb/tb_count_unwinder.sv
// Randomized bench for count_unwinder against a transaction-level unwind model.
module tb_count_unwinder;

  localparam int W = 10;
  localparam int L = 300;
`ifdef UNWIND_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [W-1:0] mdl_sn;
  logic [W-1:0] mdl_i;

  count_unwinder_if #(.WIDTH(W)) bus ();

  count_unwinder #(.WIDTH(W), .LIMIT(L)) dut (
    .clk (clk),
    .rst (rst),
    .u   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A load is rejected only when validation is built in and the snapshot is not a legal forward pair.
  function automatic bit load_rejected(input logic [W-1:0] lsn, input logic [W-1:0] li);
    logic [W-1:0] pred;
    pred = li - W'(1);
    return CHECK_EN && ((li == '0) || (int'(li) > L + 1) || (lsn != pred));
  endfunction

  task automatic clear_inputs();
    bus.load_valid = 1'b0;
    bus.selector   = 1'b0;
    bus.abort      = 1'b0;
  endtask

  task automatic check_pair(input string tag);
    check({tag, "_sn"}, 32'(bus.sn), 32'(mdl_sn));
    check({tag, "_i"},  32'(bus.i),  32'(mdl_i));
  endtask

  // mode: 0 selector held high, 1 toggling 1,0,1..., 2 random.
  // abort_after: raise abort (with selector=1) once that many steps are done; -1 never.
  task automatic run_unwind(input logic [W-1:0] lsn, input logic [W-1:0] li,
                            input int mode, input int abort_after);
    int           steps;
    logic         sel;
    logic         abt;
    logic [W-1:0] final_sn;
    check("ready_pre", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.load_sn    = lsn;
    bus.load_i     = li;
    bus.selector   = 1'($urandom_range(0, 1));
    bus.abort      = 1'($urandom_range(0, 1));
    step();
    clear_inputs();
    bus.load_sn = W'($urandom);
    bus.load_i  = W'($urandom);
    if (load_rejected(lsn, li)) begin
      check("err_pulse", 32'(bus.err), 32'd1);
      check("rej_busy", 32'(bus.busy), 32'd0);
      check_pair("rej_hold");
      step();
      check("err_clear", 32'(bus.err), 32'd0);
      check("rej_ready", 32'(bus.load_ready), 32'd1);
      return;
    end
    check("acc_err", 32'(bus.err), 32'd0);
    mdl_sn = lsn;
    mdl_i  = li;
    check_pair("acc");
    if (li <= W'(1)) begin
      check("direct_done", 32'(bus.done), 32'd1);
      check("direct_busy", 32'(bus.busy), 32'd1);
      step();
      check("direct_done_end", 32'(bus.done), 32'd0);
      check("direct_ready", 32'(bus.load_ready), 32'd1);
      check_pair("direct_hold");
      return;
    end
    check("drain_busy", 32'(bus.busy), 32'd1);
    check("drain_ready", 32'(bus.load_ready), 32'd0);
    steps = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      abt = (abort_after >= 0) && (steps == abort_after);
      if (abt)            sel = 1'b1;
      else if (mode == 0) sel = 1'b1;
      else if (mode == 1) sel = (cyc % 2 == 0);
      else                sel = 1'($urandom_range(0, 1));
      bus.selector   = sel;
      bus.abort      = abt;
      bus.load_valid = 1'($urandom_range(0, 1));
      step();
      if (abt) begin
        clear_inputs();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ready", 32'(bus.load_ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        check_pair("abort_hold");
        return;
      end
      if (sel) begin
        steps++;
        mdl_i  = mdl_i - W'(1);
        mdl_sn = mdl_sn - W'(1);
      end
      check_pair("drain");
      if (mdl_i == W'(1)) begin
        clear_inputs();
        final_sn = lsn - (li - W'(1));
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("step_count", 32'(steps), 32'(li) - 32'd1);
        check("final_sn", 32'(bus.sn), 32'(final_sn));
        step();
        check("done_end", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_ready", 32'(bus.load_ready), 32'd1);
        check_pair("idle_hold");
        return;
      end
      check("no_done", 32'(bus.done), 32'd0);
      check("still_busy", 32'(bus.busy), 32'd1);
    end
    check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [W-1:0] rsn;
    logic [W-1:0] ri;
    int           rmode;
    int           rabort;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    bus.load_sn = '0;
    bus.load_i  = '0;
    step();
    step();
    mdl_sn = '0;
    mdl_i  = W'(1);
    check_pair("reset");
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_ready", 32'(bus.load_ready), 32'd1);
    rst = 1'b0;

    // Selector and abort have no effect in IDLE.
    bus.selector = 1'b1;
    bus.abort    = 1'b1;
    step();
    step();
    clear_inputs();
    check_pair("idle_ignore");
    check("idle_ignore_busy", 32'(bus.busy), 32'd0);

    run_unwind(W'(5), W'(6), 0, -1);
    run_unwind(W'(0), W'(1), 0, -1);
    run_unwind(W'(300), W'(301), 1, -1);
    run_unwind(W'(10), W'(11), 0, 3);
    check("abort_i8", 32'(bus.i), 32'd8);
    check("abort_sn7", 32'(bus.sn), 32'd7);
    run_unwind(W'(7), W'(5), 2, -1);
    run_unwind(W'(301), W'(302), 0, -1);
    run_unwind(W'(5), W'(0), 0, -1);

    // Synchronous reset in the middle of a drain.
    run_unwind(W'(49), W'(50), 0, 0);
    bus.load_valid = 1'b1;
    bus.load_sn    = W'(49);
    bus.load_i     = W'(50);
    step();
    clear_inputs();
    bus.selector = 1'b0;
    step();
    bus.selector = 1'b1;
    rst          = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    mdl_sn = '0;
    mdl_i  = W'(1);
    check_pair("rst_mid");
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);

    for (int n = 0; n < 24; n++) begin
      ri = W'($urandom_range(0, L + 1));
      if ($urandom_range(0, 3) == 0) rsn = W'($urandom);
      else                           rsn = ri - W'(1);
      rmode  = int'($urandom_range(0, 2));
      rabort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_unwind(rsn, ri, rmode, rabort);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
